// File: rtl/ila_capture_controller_pkg.sv
// Shared types and defaults for the ILA capture controller and its readout streamer.
package ila_capture_controller_pkg;

  localparam int DEF_DATA_WIDTH    = 8;
  localparam int DEF_ADDR_WIDTH    = 4;
  localparam int DEF_HOLDOFF_WIDTH = 8;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_FILL    = 3'd1,
    ST_ARMED   = 3'd2,
    ST_HOLDOFF = 3'd3,
    ST_READOUT = 3'd4,
    ST_DONE    = 3'd5
  } cap_state_t;

  typedef enum logic [1:0] {
    RD_IDLE  = 2'd0,
    RD_FETCH = 2'd1,
    RD_VALID = 2'd2
  } rd_state_t;

  function automatic int mem_size(input int addr_width);
    return 1 << addr_width;
  endfunction

endpackage

// File: rtl/ila_capture_controller_if.sv
// Buffer RAM ports plus the valid/ready readout stream towards the host link.
interface ila_capture_controller_if #(
  parameter int DATA_WIDTH = ila_capture_controller_pkg::DEF_DATA_WIDTH,
  parameter int ADDR_WIDTH = ila_capture_controller_pkg::DEF_ADDR_WIDTH
);
  logic                  o_mem_we;
  logic [ADDR_WIDTH-1:0] o_mem_waddr;
  logic [DATA_WIDTH-1:0] o_mem_wdata;
  logic [ADDR_WIDTH-1:0] o_mem_raddr;
  logic [DATA_WIDTH-1:0] i_mem_rdata;
  logic                  o_valid;
  logic                  i_ready;
  logic [DATA_WIDTH-1:0] o_sample;
  logic                  o_last;

  modport master (
    output o_mem_we, o_mem_waddr, o_mem_wdata, o_mem_raddr,
    output o_valid, o_sample, o_last,
    input  i_mem_rdata, i_ready
  );

  modport slave (
    input  o_mem_we, o_mem_waddr, o_mem_wdata, o_mem_raddr,
    input  o_valid, o_sample, o_last,
    output i_mem_rdata, i_ready
  );
endinterface

// File: rtl/ila_capture_controller_readout.sv
// Streams the frozen buffer oldest-first: one RAM fetch, then hold valid until ready.
module ila_readout_streamer
  import ila_capture_controller_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  i_clear,
  input  logic                  i_start,
  input  logic [ADDR_WIDTH-1:0] i_start_addr,
  output logic [ADDR_WIDTH-1:0] o_raddr,
  input  logic [DATA_WIDTH-1:0] i_mem_rdata,
  output logic                  o_valid,
  input  logic                  i_ready,
  output logic [DATA_WIDTH-1:0] o_sample,
  output logic                  o_last,
  output logic                  o_done
);

  localparam logic [ADDR_WIDTH-1:0] LAST_CNT = '1;

  rd_state_t             rd_state, rd_state_d;
  logic [ADDR_WIDTH-1:0] raddr;
  logic [ADDR_WIDTH-1:0] sent_cnt;
  logic                  is_last;
  logic                  handshake;

  assign is_last   = (sent_cnt == LAST_CNT);
  assign handshake = (rd_state == RD_VALID) && i_ready;

  always_comb begin
    rd_state_d = rd_state;
    o_done     = 1'b0;
    unique case (rd_state)
      RD_IDLE:  if (i_start) rd_state_d = RD_FETCH;
      RD_FETCH: rd_state_d = RD_VALID;
      RD_VALID: begin
        if (i_ready) begin
          rd_state_d = is_last ? RD_IDLE : RD_FETCH;
          o_done     = is_last;
        end
      end
      default:  rd_state_d = RD_IDLE;
    endcase
    if (i_clear) begin
      rd_state_d = RD_IDLE;
      o_done     = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset || i_clear) begin
      rd_state <= RD_IDLE;
      raddr    <= '0;
      sent_cnt <= '0;
    end else begin
      rd_state <= rd_state_d;
      if (rd_state == RD_IDLE && i_start) begin
        raddr    <= i_start_addr;
        sent_cnt <= '0;
      end else if (handshake && !is_last) begin
        raddr    <= raddr + ADDR_WIDTH'(1);
        sent_cnt <= sent_cnt + ADDR_WIDTH'(1);
      end
    end
  end

  // Sample comes off the RAM's output register; raddr is frozen while waiting, so it holds.
  assign o_raddr  = raddr;
  assign o_valid  = (rd_state == RD_VALID);
  assign o_sample = o_valid ? i_mem_rdata : '0;
  assign o_last   = o_valid && is_last;

endmodule

// File: rtl/ila_capture_controller.sv
// Capture sequencer for the ILA circular buffer: arm, prime, trigger, holdoff, freeze, stream out.
module ila_capture_controller
  import ila_capture_controller_pkg::*;
#(
  parameter int DATA_WIDTH    = DEF_DATA_WIDTH,
  parameter int ADDR_WIDTH    = DEF_ADDR_WIDTH,
  parameter int HOLDOFF_WIDTH = DEF_HOLDOFF_WIDTH
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     i_arm,
  input  logic                     i_abort,
  input  logic                     i_trigger,
  input  logic [HOLDOFF_WIDTH-1:0] i_holdoff,
  input  logic [DATA_WIDTH-1:0]    i_data,
  ila_capture_controller_if.master bus,
  output logic [ADDR_WIDTH-1:0]    o_trig_index,
  output logic                     o_primed,
  output logic                     o_busy,
  output logic                     o_done
);

  localparam int                    MEMORY_SIZE = mem_size(ADDR_WIDTH);
  localparam logic [31:0]           HOLD_MAX    = 32'(MEMORY_SIZE - 1);
  localparam logic [ADDR_WIDTH-1:0] MAX_ADDR    = '1;
  localparam logic [ADDR_WIDTH-1:0] FILL_LAST   = {{(ADDR_WIDTH-1){1'b1}}, 1'b0};

  cap_state_t            state, state_d;
  logic [ADDR_WIDTH-1:0] waddr;
  logic [ADDR_WIDTH-1:0] fill_cnt;
  logic [ADDR_WIDTH-1:0] hold_cnt;
  logic [ADDR_WIDTH-1:0] hold_lat;
  logic [ADDR_WIDTH-1:0] trig_index;
  logic                  primed;
  logic                  mem_we;
  logic                  stream_start;
  logic                  stream_done;
  logic [ADDR_WIDTH-1:0] start_addr;

  // Holdoff never exceeds MEMORY_SIZE-1, so the trigger sample survives the freeze.
  function automatic logic [ADDR_WIDTH-1:0] clamp_holdoff(input logic [HOLDOFF_WIDTH-1:0] h);
    logic [31:0] hw;
    hw = 32'(h);
    if (hw > HOLD_MAX) return MAX_ADDR;
    return hw[ADDR_WIDTH-1:0];
  endfunction

  assign hold_lat   = clamp_holdoff(i_holdoff);
  assign mem_we     = (state == ST_FILL) || (state == ST_ARMED) || (state == ST_HOLDOFF);
  assign start_addr = waddr + ADDR_WIDTH'(1);

  always_comb begin
    state_d      = state;
    stream_start = 1'b0;
    unique case (state)
      ST_IDLE, ST_DONE: if (i_arm) state_d = ST_FILL;
      ST_FILL:          if (fill_cnt == FILL_LAST) state_d = ST_ARMED;
      ST_ARMED: begin
        if (i_trigger) begin
          state_d      = (hold_lat == '0) ? ST_READOUT : ST_HOLDOFF;
          stream_start = (hold_lat == '0);
        end
      end
      ST_HOLDOFF: begin
        if (hold_cnt == ADDR_WIDTH'(1)) begin
          state_d      = ST_READOUT;
          stream_start = 1'b1;
        end
      end
      ST_READOUT:       if (stream_done) state_d = ST_DONE;
      default:          state_d = ST_IDLE;
    endcase
    if (i_abort) begin
      state_d      = ST_IDLE;
      stream_start = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset || i_abort) begin
      state      <= ST_IDLE;
      waddr      <= '0;
      fill_cnt   <= '0;
      hold_cnt   <= '0;
      trig_index <= '0;
      primed     <= 1'b0;
    end else begin
      state <= state_d;
      if (mem_we) waddr <= waddr + ADDR_WIDTH'(1);
      unique case (state)
        ST_IDLE, ST_DONE: begin
          if (i_arm) begin
            waddr    <= '0;
            fill_cnt <= '0;
            primed   <= 1'b0;
          end
        end
        ST_FILL: begin
          fill_cnt <= fill_cnt + ADDR_WIDTH'(1);
          if (fill_cnt == FILL_LAST) primed <= 1'b1;
        end
        ST_ARMED: begin
          if (i_trigger) begin
            hold_cnt   <= hold_lat;
            trig_index <= MAX_ADDR - hold_lat;
          end
        end
        ST_HOLDOFF: hold_cnt <= hold_cnt - ADDR_WIDTH'(1);
        default: ;
      endcase
    end
  end

  ila_readout_streamer #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_streamer (
    .clk          (clk),
    .reset        (reset),
    .i_clear      (i_abort),
    .i_start      (stream_start),
    .i_start_addr (start_addr),
    .o_raddr      (bus.o_mem_raddr),
    .i_mem_rdata  (bus.i_mem_rdata),
    .o_valid      (bus.o_valid),
    .i_ready      (bus.i_ready),
    .o_sample     (bus.o_sample),
    .o_last       (bus.o_last),
    .o_done       (stream_done)
  );

  assign bus.o_mem_we    = mem_we;
  assign bus.o_mem_waddr = waddr;
  assign bus.o_mem_wdata = i_data;
  assign o_trig_index    = trig_index;
  assign o_primed        = primed;
  assign o_busy          = (state != ST_IDLE) && (state != ST_DONE);
  assign o_done          = (state == ST_DONE);

endmodule

// File: tb/tb_ila_capture_controller.sv
// Directed bench for ila_capture_controller with a behavioural 1-cycle-read buffer RAM.
module tb_ila_capture_controller;

  localparam int DW = 8;
  localparam int AW = 4;
  localparam int HW = 8;

  logic          clk = 1'b0;
  logic          reset;
  logic          i_arm;
  logic          i_abort;
  logic          i_trigger;
  logic [HW-1:0] i_holdoff;
  logic [DW-1:0] i_data;
  logic [AW-1:0] o_trig_index;
  logic          o_primed;
  logic          o_busy;
  logic          o_done;

  always #5 clk = ~clk;

  ila_capture_controller_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

  ila_capture_controller #(
    .DATA_WIDTH    (DW),
    .ADDR_WIDTH    (AW),
    .HOLDOFF_WIDTH (HW)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .i_arm        (i_arm),
    .i_abort      (i_abort),
    .i_trigger    (i_trigger),
    .i_holdoff    (i_holdoff),
    .i_data       (i_data),
    .bus          (bus),
    .o_trig_index (o_trig_index),
    .o_primed     (o_primed),
    .o_busy       (o_busy),
    .o_done       (o_done)
  );

  logic [DW-1:0] ram [16];

  always @(posedge clk) begin
    if (bus.o_mem_we) ram[bus.o_mem_waddr] <= bus.o_mem_wdata;
    bus.i_mem_rdata <= ram[bus.o_mem_raddr];
  end

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Arms, feeds sample numbers 0,1,2.. as i_data and runs until writes stop (or abort).
  task automatic capture(input int trig_at, input int fill_pulse, input int hold,
                         input bit trig_all, input int abort_at, input int exp_tidx);
    int samp;
    int n;
    i_holdoff = HW'(hold);
    @(negedge clk);
    i_arm     = 1'b1;
    i_trigger = trig_all;
    @(negedge clk);
    i_arm = 1'b0;
    chk("arm_we",     32'(bus.o_mem_we), 1);
    chk("arm_waddr",  32'(bus.o_mem_waddr), 0);
    chk("arm_primed", 32'(o_primed), 0);
    chk("arm_done",   32'(o_done), 0);
    chk("arm_busy",   32'(o_busy), 1);
    samp = 0;
    n    = 0;
    while (bus.o_mem_we && n < 300) begin
      chk("waddr", 32'(bus.o_mem_waddr), samp & 15);
      if (samp == 14) chk("primed_early", 32'(o_primed), 0);
      if (samp == 15) chk("primed", 32'(o_primed), 1);
      i_data    = DW'(samp);
      i_arm     = (samp == 3);
      i_trigger = trig_all || (samp == trig_at) || (samp == fill_pulse);
      i_abort   = (samp == abort_at);
      if (samp == 7) begin
        #1;
        chk("wdata_pass", 32'(bus.o_mem_wdata), 7);
      end
      @(negedge clk);
      if (i_abort) begin
        i_abort   = 1'b0;
        i_arm     = 1'b0;
        i_trigger = 1'b0;
        chk("abort_busy",   32'(o_busy), 0);
        chk("abort_we",     32'(bus.o_mem_we), 0);
        chk("abort_waddr",  32'(bus.o_mem_waddr), 0);
        chk("abort_primed", 32'(o_primed), 0);
        chk("abort_tidx",   32'(o_trig_index), 0);
        chk("abort_valid",  32'(bus.o_valid), 0);
        return;
      end
      samp++;
      n++;
    end
    i_arm     = 1'b0;
    i_trigger = 1'b0;
    chk("capture_bound", 32'(n < 300), 1);
    chk("trig_index", 32'(o_trig_index), exp_tidx);
  endtask

  task automatic readout(input int exp_first, input bit rand_ready, input int abort_after);
    int            idx;
    int            cyc;
    bit            waiting;
    bit            rdy;
    logic [DW-1:0] held;
    idx     = 0;
    cyc     = 0;
    waiting = 1'b0;
    held    = '0;
    for (int k = 0; k < 600; k++) begin
      if (o_done) break;
      if (abort_after >= 0 && idx == abort_after && bus.o_valid) begin
        bus.i_ready = 1'b0;
        i_abort     = 1'b1;
        @(negedge clk);
        i_abort = 1'b0;
        chk("rd_abort_valid",  32'(bus.o_valid), 0);
        chk("rd_abort_last",   32'(bus.o_last), 0);
        chk("rd_abort_sample", 32'(bus.o_sample), 0);
        chk("rd_abort_raddr",  32'(bus.o_mem_raddr), 0);
        chk("rd_abort_busy",   32'(o_busy), 0);
        chk("rd_abort_done",   32'(o_done), 0);
        return;
      end
      rdy = rand_ready ? ($urandom_range(0, 9) < 3) : 1'b1;
      bus.i_ready = rdy;
      if (bus.o_valid) begin
        if (waiting) chk("hold_sample", 32'(bus.o_sample), 32'(held));
        if (rdy) begin
          chk("sample", 32'(bus.o_sample), exp_first + idx);
          chk("last",   32'(bus.o_last), (idx == 15) ? 1 : 0);
          idx++;
          waiting = 1'b0;
        end else begin
          waiting = 1'b1;
          held    = bus.o_sample;
        end
      end
      @(negedge clk);
      cyc++;
    end
    bus.i_ready = 1'b1;
    chk("handshakes", idx, 16);
    if (!rand_ready) chk("readout_cycles", cyc, 32);
    chk("done",        32'(o_done), 1);
    chk("done_busy",   32'(o_busy), 0);
    chk("done_valid",  32'(bus.o_valid), 0);
    chk("done_primed", 32'(o_primed), 1);
  endtask

  initial begin
    reset       = 1'b1;
    i_arm       = 1'b0;
    i_abort     = 1'b0;
    i_trigger   = 1'b0;
    i_holdoff   = '0;
    i_data      = '0;
    bus.i_ready = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("rst_we",     32'(bus.o_mem_we), 0);
    chk("rst_waddr",  32'(bus.o_mem_waddr), 0);
    chk("rst_raddr",  32'(bus.o_mem_raddr), 0);
    chk("rst_valid",  32'(bus.o_valid), 0);
    chk("rst_last",   32'(bus.o_last), 0);
    chk("rst_sample", 32'(bus.o_sample), 0);
    chk("rst_tidx",   32'(o_trig_index), 0);
    chk("rst_primed", 32'(o_primed), 0);
    chk("rst_busy",   32'(o_busy), 0);
    chk("rst_done",   32'(o_done), 0);

    // trigger at 40, holdoff 3: stream 28..43, trigger at index 12
    capture(40, -1, 3, 1'b0, -1, 12);
    readout(28, 1'b0, -1);
    // trigger during FILL ignored, real trigger at 20, holdoff 0: stream 5..20
    capture(20, 5, 0, 1'b0, -1, 15);
    readout(5, 1'b0, -1);
    // holdoff 200 clamps to 15: stream 30..45
    capture(30, -1, 200, 1'b0, -1, 0);
    readout(30, 1'b0, -1);
    // trigger 25, holdoff 5, 30% ready duty: stream 15..30
    capture(25, -1, 5, 1'b0, -1, 10);
    readout(15, 1'b1, -1);
    // abort inside holdoff, then a clean capture
    capture(20, -1, 10, 1'b0, 24, 0);
    capture(40, -1, 3, 1'b0, -1, 12);
    readout(28, 1'b0, -1);
    // abort after 5 handshakes, then a clean capture
    capture(18, -1, 1, 1'b0, -1, 14);
    readout(4, 1'b0, 5);
    capture(40, -1, 3, 1'b0, -1, 12);
    readout(28, 1'b0, -1);
    // re-arm from DONE with trigger held high: fires on sample 15, holdoff 2 -> 2..17
    capture(0, -1, 2, 1'b1, -1, 13);
    readout(2, 1'b0, -1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ila_capture_controller.md
Name: ila_capture_controller

Overview:
Sequencing controller for the internal logic analyzer's circular capture buffer. It runs one capture per request: arm, prime (fill the buffer once), wait for trigger, count holdoff, freeze. It then streams the frozen buffer out oldest-first over a valid/ready interface to a host link (UART/JTAG bridge). It owns the buffer's write and read ports; the RAM itself is external, single-clock, with a 1-cycle synchronous read.

Parameters:
DATA_WIDTH, 8, sample width
ADDR_WIDTH, 4, buffer address width; MEMORY_SIZE = 2**ADDR_WIDTH
HOLDOFF_WIDTH, 8, width of programmable holdoff

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high
i_arm  in  1  start a capture (accepted in IDLE or DONE)
i_abort  in  1  return to IDLE from any state
i_trigger  in  1  trigger qualifier, sampled every cycle
i_holdoff  in  HOLDOFF_WIDTH  post-trigger samples; latched on trigger
i_data  in  DATA_WIDTH  probed signals
o_mem_we  out  1  buffer write enable
o_mem_waddr  out  ADDR_WIDTH  buffer write address
o_mem_wdata  out  DATA_WIDTH  equals i_data (combinational pass-through)
o_mem_raddr  out  ADDR_WIDTH  buffer read address
i_mem_rdata  in  DATA_WIDTH  read data, valid 1 cycle after raddr
o_valid  out  1  readout sample valid
i_ready  in  1  host accepts sample
o_sample  out  DATA_WIDTH  readout sample (registered)
o_last  out  1  qualifies the final sample, with o_valid
o_trig_index  out  ADDR_WIDTH  readout position of the trigger sample
o_primed  out  1  buffer filled once since arm
o_busy  out  1  state not in {IDLE, DONE}
o_done  out  1  readout complete

Behaviour:
- Reset and abort: state IDLE. Every output 0, including all counters and pointers. i_abort has priority over every other input. i_abort or reset during READOUT drops o_valid the next cycle, with no o_last.
- States: IDLE, FILL, ARMED, HOLDOFF, READOUT, DONE.
- IDLE or DONE + i_arm -> FILL. The arm clears waddr, the fill counter, o_primed and o_done.
- FILL, ARMED, HOLDOFF: o_mem_we=1 every cycle; waddr increments modulo MEMORY_SIZE after each write.
- FILL: i_trigger ignored. When the fill counter reaches MEMORY_SIZE-1 writes: o_primed=1 next cycle, state -> ARMED.
- ARMED + i_trigger: the write this cycle is the trigger sample. Latch h = min(i_holdoff, MEMORY_SIZE-1). The clamp guarantees the trigger sample is kept.
  - h=0: the trigger write is the last write -> READOUT.
  - Otherwise -> HOLDOFF with count h.
- HOLDOFF: one write per cycle, count decrements; the write made when count=1 is the last -> READOUT.
- o_trig_index = MEMORY_SIZE-1-h, set on the trigger cycle.
- Buffer contents at freeze: the oldest sample sits at the final waddr, i.e. the address after the last write.
- READOUT: o_mem_we=0; raddr starts at the final waddr.
  - Per sample: raddr is presented in cycle N; o_sample is loaded and o_valid=1 in cycle N+1.
  - o_valid and o_sample hold until i_ready. The handshake cycle advances raddr (wrap modulo MEMORY_SIZE).
  - Throughput: 1 sample per 2 cycles with i_ready tied high.
  - Exactly MEMORY_SIZE samples; o_last=1 with the final one.
  - The handshake on the last sample -> DONE.
- DONE: o_done=1, o_primed held, readout idle until the next i_arm.
- i_arm outside IDLE/DONE: ignored. i_trigger outside ARMED: ignored. i_trigger held high: only the first edge in ARMED counts.

Decomposition:
- Shared package/define file: state encoding localparams, MEMORY_SIZE derivation, default widths.
- One natural sub-module: ila_readout_streamer. It owns raddr, the 1-cycle read latency, the valid/ready hold and o_last. It is started by a pulse plus a start address, and returns a done pulse.

Test Plan:
- MEMORY_SIZE=16, arm, i_data=cycle count, trigger at sample 40, holdoff=3, i_ready=1.
  - Expected stream: samples 28..43 in order; o_trig_index=12; o_last on 43; then o_done=1.
- Trigger pulsed during FILL (sample 5), then again at sample 20, holdoff=0.
  - First trigger ignored; stream is 5..20; o_trig_index=15.
- Holdoff=200, trigger at 30.
  - Clamped to 15; stream 30..45; o_trig_index=0.
- Readout with i_ready random 30% duty.
  - o_sample stable while o_valid && !i_ready; no sample dropped or duplicated; 16 handshakes total.
- i_abort mid-HOLDOFF, then mid-READOUT (after 5 handshakes).
  - IDLE next cycle; o_valid/o_mem_we=0; re-arm produces a clean full capture.
- Re-arm from DONE while i_trigger is held high.
  - o_primed cleared; trigger accepted on the first ARMED cycle (sample 15 of new capture).
